// File: rtl/fire2_expand1_ctrl.sv
// fire2_expand1_ctrl
// Sequencer for the fire2 expand1 (1x1) layer. For every output pixel it
// sweeps all 2**ADDR squeeze channels through the shared weight ROM and the
// input-feature buffer while strobing the MAC array. It waits MAC_LAT cycles
// for the MAC pipeline to settle, then presents the pixel downstream over a
// valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           frame start request (only honoured in IDLE)
//   rom_addr        weight-ROM address, equal to the current channel
//   ifm_pix/ifm_ch  input-feature buffer read address (pixel, channel)
//   mac_en          MAC accumulate enable
//   mac_clr         MAC load-instead-of-accumulate on the first channel
//   out_valid       MAC results for out_pix are final
//   out_ready       downstream accepts the presented pixel
//   out_pix         pixel index being presented
//   busy            high whenever a frame is in progress
//   done            one-cycle pulse after the last pixel is accepted
module fire2_expand1_ctrl #(
  parameter int ADDR    = 4,
  parameter int PIX_W   = 12,
  parameter int NUM_PIX = 3025,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ADDR-1:0]  rom_addr,
  output logic [PIX_W-1:0] ifm_pix,
  output logic [ADDR-1:0]  ifm_ch,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } state_t;

  localparam logic [ADDR-1:0]  CH_LAST  = '1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic [2:0]       LAT      = 3'(MAC_LAT);

  state_t           state;
  state_t           state_nxt;
  logic [ADDR-1:0]  ch;
  logic [PIX_W-1:0] pix;
  logic [2:0]       dly;
  logic             done_q;

  logic ch_last;
  logic pix_last;
  logic handshake;

  assign ch_last   = (ch == CH_LAST);
  assign pix_last  = (pix == PIX_LAST);
  assign handshake = (state == OUT) && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACC;
      end
      ACC: begin
        if (ch_last) begin
          // With no MAC latency the results are final right after the sweep.
          state_nxt = (LAT == 3'd0) ? OUT : DRAIN;
        end
      end
      DRAIN: begin
        if (dly <= 3'd1) state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) state_nxt = pix_last ? IDLE : ACC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel / pixel / drain counters and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch     <= '0;
      pix    <= '0;
      dly    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= handshake && pix_last;
      case (state)
        IDLE: begin
          ch  <= '0;
          pix <= '0;
          dly <= '0;
        end
        ACC: begin
          ch <= ch + 1'b1;
          if (ch_last) dly <= LAT;
        end
        DRAIN: begin
          dly <= dly - 1'b1;
        end
        OUT: begin
          if (out_ready) pix <= pix_last ? '0 : pix + 1'b1;
        end
        default: begin
          ch  <= '0;
          pix <= '0;
          dly <= '0;
        end
      endcase
    end
  end

  // Moore output decode; nothing here depends on out_ready or start.
  always_comb begin
    rom_addr  = ch;
    ifm_ch    = ch;
    ifm_pix   = pix;
    mac_en    = (state == ACC);
    mac_clr   = (state == ACC) && (ch == '0);
    out_valid = (state == OUT);
    out_pix   = (state == OUT) ? pix : '0;
    busy      = (state != IDLE);
    done      = done_q;
  end

endmodule
